// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device using the host-request sequence.
// The host inhibits the bus by holding clock low, then pulls data low as the
// start bit (request-to-send) and releases clock. The device then clocks out
// the data bits, the odd parity bit and the stop bit. Finally the device
// drives an ack on the 11th clock. The host changes data only after falling
// edges it has detected. The device samples data on its own rising edges.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   ps2_clk_in   PS/2 clock line as seen on the wire (asynchronous)
//   ps2_data_in  PS/2 data line as seen on the wire (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low (open collector)
//   ps2_data_oe  1 = pull PS/2 data low (open collector)
//   tx_data      byte to send, latched on accept
//   tx_valid     send request
//   tx_ready     1 only while idle; accept = tx_valid && tx_ready
//   tx_done      1-cycle pulse at the end of every accepted transfer
//   tx_ack_ok    device acked (meaningful with tx_done, held until next accept)
//   tx_timeout   transfer aborted on timeout (same validity as tx_ack_ok)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_DEV,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        clk_sync_reg;
  logic [1:0]        data_sync_reg;
  logic [7:0]        byte_reg, byte_next;
  logic              parity_reg, parity_next;
  logic [3:0]        edge_idx_reg, edge_idx_next;
  logic [INH_W-1:0]  inh_cnt_reg, inh_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              clk_oe_reg, clk_oe_next;
  logic              data_oe_reg, data_oe_next;
  logic              ack_ok_reg, ack_ok_next;
  logic              timeout_reg, timeout_next;

  logic clk_fall;
  logic clk_s;
  logic data_s;
  logic timed;
  logic timeout_hit;

  // Clock and data share the same two-flop delay so that the data sample
  // taken at a detected falling edge lines up with that edge.
  assign clk_fall = (clk_sync_reg[2:1] == 2'b10);
  assign clk_s    = clk_sync_reg[1];
  assign data_s   = data_sync_reg[1];

  // The timeout window opens on entry to REQ and covers everything up to
  // the return to idle.
  assign timed       = (state_reg inside {S_REQ, S_WAIT_DEV, S_SEND, S_ACK, S_WAIT_IDLE});
  assign timeout_hit = timed && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      // Lines idle high, so reset the synchronizers to 1 to avoid a false
      // falling edge straight out of reset.
      clk_sync_reg  <= 3'b111;
      data_sync_reg <= 2'b11;
      byte_reg      <= 8'h00;
      parity_reg    <= 1'b0;
      edge_idx_reg  <= 4'd0;
      inh_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      clk_oe_reg    <= 1'b0;
      data_oe_reg   <= 1'b0;
      ack_ok_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk_in};
      data_sync_reg <= {data_sync_reg[0], ps2_data_in};
      byte_reg      <= byte_next;
      parity_reg    <= parity_next;
      edge_idx_reg  <= edge_idx_next;
      inh_cnt_reg   <= inh_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      clk_oe_reg    <= clk_oe_next;
      data_oe_reg   <= data_oe_next;
      ack_ok_reg    <= ack_ok_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Line enables are registered from the next state, so they always match
  // the state they belong to and never glitch.
  always_comb begin
    state_next    = state_reg;
    byte_next     = byte_reg;
    parity_next   = parity_reg;
    edge_idx_next = edge_idx_reg;
    inh_cnt_next  = inh_cnt_reg;
    to_cnt_next   = timed ? (to_cnt_reg + TO_W'(1)) : to_cnt_reg;
    clk_oe_next   = 1'b0;
    data_oe_next  = 1'b0;
    ack_ok_next   = ack_ok_reg;
    timeout_next  = timeout_reg;

    case (state_reg)
      S_IDLE: begin
        if (tx_valid) begin
          byte_next     = tx_data;
          parity_next   = ~^tx_data;
          edge_idx_next = 4'd0;
          inh_cnt_next  = '0;
          ack_ok_next   = 1'b0;
          timeout_next  = 1'b0;
          clk_oe_next   = 1'b1;
          state_next    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        clk_oe_next  = 1'b1;
        inh_cnt_next = inh_cnt_reg + INH_W'(1);
        if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_next = 1'b1;
          to_cnt_next  = '0;
          state_next   = S_REQ;
        end
      end

      // Clock and data both low for one cycle: the start bit is on the wire
      // before the clock is released.
      S_REQ: begin
        data_oe_next = 1'b1;
        state_next   = S_WAIT_DEV;
      end

      S_WAIT_DEV: begin
        data_oe_next = 1'b1;
        if (clk_fall) begin
          edge_idx_next = 4'd1;
          data_oe_next  = ~byte_reg[0];
          state_next    = S_SEND;
        end
      end

      // edge_idx_reg holds the number of the last edge seen, so edge n
      // (2..8) sends bit n-1 = byte_reg[edge_idx_reg].
      S_SEND: begin
        data_oe_next = data_oe_reg;
        if (clk_fall) begin
          edge_idx_next = edge_idx_reg + 4'd1;
          if (edge_idx_reg <= 4'd7) begin
            data_oe_next = ~byte_reg[edge_idx_reg[2:0]];
          end else if (edge_idx_reg == 4'd8) begin
            data_oe_next = ~parity_reg;
          end else begin
            data_oe_next = 1'b0;   // stop bit: release data
            state_next   = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (clk_fall) begin
          edge_idx_next = 4'd11;
          ack_ok_next   = ~data_s;
          state_next    = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Timeout overrides whatever the state logic decided, including a
    // completion in the same cycle.
    if (timeout_hit) begin
      state_next   = S_DONE;
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      ack_ok_next  = 1'b0;
      timeout_next = 1'b1;
    end
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_ready    = (state_reg == S_IDLE);
  assign tx_done     = (state_reg == S_DONE);
  assign tx_ack_ok   = ack_ok_reg;
  assign tx_timeout  = timeout_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed test of ps2_host_tx with a simple PS/2 device model.
// The device model clocks at a 40-cycle period, samples data on its rising
// edges and optionally acks on the 11th clock.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_timeout;
  logic       clk_oe;
  logic       data_oe;
  logic       dev_clk_low;
  logic       dev_data_low;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  int n_checks;
  int n_pass;

  // Open-collector wiring: a line is high unless someone pulls it low.
  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(8),
    .TIMEOUT_CYCLES(4000)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_ack_ok   (tx_ack_ok),
    .tx_timeout  (tx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte for one clock; reports tx_ready as seen at the accept edge.
  task automatic start_tx(input logic [7:0] b, output bit rdy);
    tx_data  = b;
    tx_valid = 1'b1;
    rdy      = tx_ready;
    step();
    tx_valid = 1'b0;
  endtask

  // Counts cycles with clock pulled and data released; ends on the REQ cycle.
  task automatic measure_inhibit(output int n);
    n = 0;
    while (clk_oe && !data_oe && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic wait_done(output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (n < 5000) begin
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  // Device model: waits for the request, records the start bit, then
  // generates n_edges clock pulses sampling data at each rising edge.
  // With a full frame it adds the 11th clock, pulling data low if do_ack.
  task automatic bfm_frame(input int n_edges, input bit do_ack,
                           output logic [10:0] f, output bit ok);
    int n;
    f  = '0;
    ok = 1'b0;
    n  = 0;
    while (!(clk_oe == 1'b0 && ps2_data_line == 1'b0) && n < 2000) begin
      step();
      n++;
    end
    if (n < 2000) begin
      f[0] = ps2_data_line;
      repeat (10) step();
      for (int i = 1; i <= n_edges; i++) begin
        dev_clk_low = 1'b1;
        repeat (20) step();
        dev_clk_low = 1'b0;
        f[i] = ps2_data_line;
        repeat (20) step();
      end
      if (n_edges >= 10) begin
        if (do_ack) dev_data_low = 1'b1;
        repeat (5) step();
        dev_clk_low = 1'b1;
        repeat (20) step();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
      end
      ok = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit do_ack,
                           output bit rdy, output int n_inh, output bit req_ok,
                           output bit wdev_ok, output logic [10:0] f,
                           output bit bfm_ok, output bit seen, output bit ack_o,
                           output bit to_o, output bit done_after,
                           output bit ready_after, output bit ack_held);
    int          ni, nd;
    bit          r, w, s, a, t, ok;
    logic [10:0] fr;
    start_tx(b, rdy);
    fork
      begin
        measure_inhibit(ni);
        r = clk_oe && data_oe;
        step();
        w = !clk_oe && data_oe;
        wait_done(nd, s);
        a = tx_ack_ok;
        t = tx_timeout;
      end
      begin
        bfm_frame(10, do_ack, fr, ok);
      end
    join
    step();
    n_inh       = ni;
    req_ok      = r;
    wdev_ok     = w;
    f           = fr;
    bfm_ok      = ok;
    seen        = s;
    ack_o       = a;
    to_o        = t;
    done_after  = tx_done;
    ready_after = tx_ready;
    ack_held    = (tx_ack_ok === a);
    $display("tx %h: frame %h done %b ack_ok %b timeout %b", b, f, s, a, t);
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", tx_ready); else n_pass++;
    n_checks++; if ({clk_oe, data_oe} !== 2'b00) $display("FAIL reset_oe: got %b want 00", {clk_oe, data_oe}); else n_pass++;
    n_checks++; if ({tx_done, tx_ack_ok, tx_timeout} !== 3'b000) $display("FAIL reset_status: got %b want 000", {tx_done, tx_ack_ok, tx_timeout}); else n_pass++;
    resetn = 1'b1;
    repeat (3) step();
    n_checks++; if ({tx_ready, clk_oe, data_oe} !== 3'b100) $display("FAIL reset_idle: got %b want 100", {tx_ready, clk_oe, data_oe}); else n_pass++;
    $display("reset: ready %b oe %b%b", tx_ready, clk_oe, data_oe);
  endtask

  task automatic test_send_ed();
    bit rdy, req, wdev, ok, seen, a, t, da, ra, held;
    int n_inh;
    logic [10:0] f;
    run_frame(8'hED, 1'b1, rdy, n_inh, req, wdev, f, ok, seen, a, t, da, ra, held);
    n_checks++; if (rdy !== 1'b1) $display("FAIL ed_ready_at_accept: got %b want 1", rdy); else n_pass++;
    n_checks++; if (n_inh !== 8) $display("FAIL ed_inhibit_cycles: got %0d want 8", n_inh); else n_pass++;
    n_checks++; if (req !== 1'b1) $display("FAIL ed_req_both_low: got %b want 1", req); else n_pass++;
    n_checks++; if (wdev !== 1'b1) $display("FAIL ed_wait_dev: got %b want 1", wdev); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL ed_bfm_request: got %b want 1", ok); else n_pass++;
    n_checks++; if (f !== 11'h7DA) $display("FAIL ed_frame: got %h want 7da", f); else n_pass++;
    n_checks++; if (seen !== 1'b1) $display("FAIL ed_done: got %b want 1", seen); else n_pass++;
    n_checks++; if ({a, t} !== 2'b10) $display("FAIL ed_status: got ack %b to %b want ack 1 to 0", a, t); else n_pass++;
    n_checks++; if (da !== 1'b0) $display("FAIL ed_done_one_cycle: got %b want 0", da); else n_pass++;
    n_checks++; if (ra !== 1'b1) $display("FAIL ed_ready_after: got %b want 1", ra); else n_pass++;
    n_checks++; if (held !== 1'b1) $display("FAIL ed_ack_held: got %b want 1", held); else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0]  bytes [3];
    logic [10:0] frames [3];
    bit rdy, req, wdev, ok, seen, a, t, da, ra, held;
    int n_inh;
    logic [10:0] f;
    bytes[0] = 8'h01; frames[0] = 11'h402;  // parity 0
    bytes[1] = 8'hFF; frames[1] = 11'h7FE;  // parity 1
    bytes[2] = 8'h00; frames[2] = 11'h600;  // parity 1
    for (int i = 0; i < 3; i++) begin
      run_frame(bytes[i], 1'b1, rdy, n_inh, req, wdev, f, ok, seen, a, t, da, ra, held);
      n_checks++; if (f !== frames[i]) $display("FAIL parity_frame_%h: got %h want %h", bytes[i], f, frames[i]); else n_pass++;
      n_checks++; if ({seen, a, t} !== 3'b110) $display("FAIL parity_status_%h: got done/ack/to %b want 110", bytes[i], {seen, a, t}); else n_pass++;
    end
  endtask

  task automatic test_nack();
    bit rdy, req, wdev, ok, seen, a, t, da, ra, held;
    int n_inh;
    logic [10:0] f;
    run_frame(8'h01, 1'b0, rdy, n_inh, req, wdev, f, ok, seen, a, t, da, ra, held);
    n_checks++; if (f !== 11'h402) $display("FAIL nack_frame: got %h want 402", f); else n_pass++;
    n_checks++; if ({seen, a, t} !== 3'b100) $display("FAIL nack_status: got done/ack/to %b want 100", {seen, a, t}); else n_pass++;
  endtask

  task automatic test_timeout();
    bit rdy, seen, held;
    int n_inh, n;
    start_tx(8'hA5, rdy);
    measure_inhibit(n_inh);
    n_checks++; if ({clk_oe, data_oe} !== 2'b11) $display("FAIL to_req: got %b want 11", {clk_oe, data_oe}); else n_pass++;
    n    = 0;
    seen = 1'b0;
    held = 1'b1;
    while (n < 5000) begin
      step();
      n++;
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
      if (!(data_oe && !clk_oe)) held = 1'b0;
    end
    $display("tx a5: timeout after %0d cycles done %b ack_ok %b timeout %b", n, seen, tx_ack_ok, tx_timeout);
    n_checks++; if (seen !== 1'b1) $display("FAIL to_done: got %b want 1", seen); else n_pass++;
    n_checks++; if (n !== 4000) $display("FAIL to_cycles: got %0d want 4000", n); else n_pass++;
    n_checks++; if (held !== 1'b1) $display("FAIL to_lines_held: got %b want 1", held); else n_pass++;
    n_checks++; if ({clk_oe, data_oe} !== 2'b00) $display("FAIL to_release: got %b want 00", {clk_oe, data_oe}); else n_pass++;
    n_checks++; if ({tx_ack_ok, tx_timeout} !== 2'b01) $display("FAIL to_status: got ack/to %b want 01", {tx_ack_ok, tx_timeout}); else n_pass++;
    step();
  endtask

  task automatic test_ignore_and_reset();
    bit rdy, ok, seen, busy_ready, done_seen;
    int nd;
    logic [10:0] f;
    // tx_valid with a different byte mid-frame must not disturb the frame.
    start_tx(8'h3C, rdy);
    busy_ready = 1'b1;
    fork
      bfm_frame(10, 1'b1, f, ok);
      wait_done(nd, seen);
      begin
        repeat (130) step();
        tx_data    = 8'h55;
        tx_valid   = 1'b1;
        busy_ready = tx_ready;
        repeat (200) step();
        tx_valid   = 1'b0;
      end
    join
    $display("tx 3c with 55 offered mid-frame: frame %h ack_ok %b", f, tx_ack_ok);
    n_checks++; if (busy_ready !== 1'b0) $display("FAIL ign_ready_busy: got %b want 0", busy_ready); else n_pass++;
    n_checks++; if (f !== 11'h678) $display("FAIL ign_frame: got %h want 678", f); else n_pass++;
    n_checks++; if ({seen, tx_ack_ok} !== 2'b11) $display("FAIL ign_status: got done/ack %b want 11", {seen, tx_ack_ok}); else n_pass++;
    repeat (3) step();
    n_checks++; if ({tx_ready, clk_oe} !== 2'b10) $display("FAIL ign_no_reaccept: got ready/clk_oe %b want 10", {tx_ready, clk_oe}); else n_pass++;

    // Reset after edge 5 of an all-zero byte, while data is being pulled.
    start_tx(8'h00, rdy);
    bfm_frame(5, 1'b0, f, ok);
    n_checks++; if (f[5:0] !== 6'b000000) $display("FAIL rst_partial_frame: got %b want 000000", f[5:0]); else n_pass++;
    n_checks++; if ({tx_ready, data_oe} !== 2'b01) $display("FAIL rst_mid_frame: got ready/data_oe %b want 01", {tx_ready, data_oe}); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if ({clk_oe, data_oe} !== 2'b00) $display("FAIL rst_release_now: got %b want 00", {clk_oe, data_oe}); else n_pass++;
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx_done) done_seen = 1'b1;
    end
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_done) done_seen = 1'b1;
    end
    $display("tx 00 reset after edge 5: done_seen %b ready %b", done_seen, tx_ready);
    n_checks++; if (done_seen !== 1'b0) $display("FAIL rst_no_done: got %b want 0", done_seen); else n_pass++;
    n_checks++; if ({tx_ready, clk_oe, data_oe} !== 3'b100) $display("FAIL rst_idle_after: got %b want 100", {tx_ready, clk_oe, data_oe}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, s1, s2, a1;
    int n1, n2;
    logic [10:0] f1, f2;
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    fork
      bfm_frame(10, 1'b1, f1, ok1);
      wait_done(n1, s1);
    join
    a1 = tx_ack_ok;
    step();
    n_checks++; if ({tx_ready, clk_oe} !== 2'b10) $display("FAIL b2b_first_idle: got ready/clk_oe %b want 10", {tx_ready, clk_oe}); else n_pass++;
    step();
    n_checks++; if ({tx_ready, clk_oe} !== 2'b01) $display("FAIL b2b_reaccept: got ready/clk_oe %b want 01", {tx_ready, clk_oe}); else n_pass++;
    tx_valid = 1'b0;
    fork
      bfm_frame(10, 1'b1, f2, ok2);
      wait_done(n2, s2);
    join
    $display("tx f4 x2: frame1 %h frame2 %h ack_ok %b %b", f1, f2, a1, tx_ack_ok);
    n_checks++; if ({s1, a1} !== 2'b11) $display("FAIL b2b_first_status: got done/ack %b want 11", {s1, a1}); else n_pass++;
    n_checks++; if (f1 !== 11'h5E8) $display("FAIL b2b_frame1: got %h want 5e8", f1); else n_pass++;
    n_checks++; if (f2 !== 11'h5E8) $display("FAIL b2b_frame2: got %h want 5e8", f2); else n_pass++;
    n_checks++; if ({s2, tx_ack_ok, tx_timeout} !== 3'b110) $display("FAIL b2b_second_status: got %b want 110", {s2, tx_ack_ok, tx_timeout}); else n_pass++;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_send_ed();
    test_parity();
    test_timeout();
    test_nack();
    test_ignore_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
